wb_cmd_master: RTL and testbench

- Wishbone classic master sequencer directly upstream of the USB core's Wishbone slave port in the FX2 testbench top.
- Accepts single read/write commands on a valid/ready stream from the cocotb driver and runs each one as one Wishbone classic cycle.
- Returns one response per command with read data and status: ack, err, or timeout.
- Keeps transaction and error counters, plus a sticky flag for spurious slave responses.

---
 rtl/wb_cmd_master.sv | 206 ++++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Brief    : Turns single read/write commands from a valid/ready stream into
//            Wishbone classic cycles. Each cycle ends in ack, err or timeout
//            and produces one response. Also keeps transaction and error
//            counters and a sticky flag for slave responses seen outside a
//            cycle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_master #(
  parameter int ADR_W   = 30,
  parameter int DAT_W   = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  // command stream
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  // response stream
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic [1:0]       rsp_status,
  // Wishbone master port
  output logic [ADR_W-1:0] wb_adr,
  output logic [DAT_W-1:0] wb_dat_w,
  input  logic [DAT_W-1:0] wb_dat_r,
  output logic [SEL_W-1:0] wb_sel,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  input  logic             wb_ack,
  input  logic             wb_err,
  output logic [2:0]       wb_cti,
  output logic [1:0]       wb_bte,
  // status
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count,
  output logic             spurious
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);
  localparam logic [1:0]  c_st_ack   = 2'b00;
  localparam logic [1:0]  c_st_err   = 2'b01;
  localparam logic [1:0]  c_st_tmo   = 2'b10;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic             w_done;
  logic             w_rsp_take;
  logic [1:0]       w_status;
  logic [DAT_W-1:0] w_rsp_dat;

  logic             r_cmd_ready;
  logic [ADR_W-1:0] r_wb_adr;
  logic [DAT_W-1:0] r_wb_dat_w;
  logic [SEL_W-1:0] r_wb_sel;
  logic             r_wb_cyc;
  logic             r_wb_we;
  logic             r_rsp_valid;
  logic [DAT_W-1:0] r_rsp_dat;
  logic [1:0]       r_rsp_status;
  logic [15:0]      r_tmo;
  logic [CNT_W-1:0] r_txn_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_spurious;

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_dat    = r_rsp_dat;
  assign rsp_status = r_rsp_status;
  assign wb_adr     = r_wb_adr;
  assign wb_dat_w   = r_wb_dat_w;
  assign wb_sel     = r_wb_sel;
  assign wb_cyc     = r_wb_cyc;
  assign wb_stb     = r_wb_cyc;   // classic single cycles: strobe tracks cycle
  assign wb_we      = r_wb_we;
  assign wb_cti     = 3'b000;
  assign wb_bte     = 2'b00;
  assign txn_count  = r_txn_count;
  assign err_count  = r_err_count;
  assign spurious   = r_spurious;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and termination classification (err beats ack)
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_rsp_take   = 1'b0;
    w_status     = c_st_ack;
    w_rsp_dat    = '0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept     = 1'b1;
          w_next_state = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_err) begin
          w_done       = 1'b1;
          w_status     = c_st_err;
          w_next_state = ST_RSP;
        end else if (wb_ack) begin
          w_done       = 1'b1;
          w_status     = c_st_ack;
          w_rsp_dat    = r_wb_we ? '0 : wb_dat_r;
          w_next_state = ST_RSP;
        end else if (r_tmo == c_tmo_last) begin
          w_done       = 1'b1;
          w_status     = c_st_tmo;
          w_next_state = ST_RSP;
        end
      end
      ST_RSP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_take   = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Bus, response, counter and spurious-flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_ready  <= 1'b0;
      r_wb_adr     <= '0;
      r_wb_dat_w   <= '0;
      r_wb_sel     <= '0;
      r_wb_cyc     <= 1'b0;
      r_wb_we      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= 2'b00;
      r_tmo        <= 16'd0;
      r_txn_count  <= '0;
      r_err_count  <= '0;
      r_spurious   <= 1'b0;
    end else begin
      // ready is a flop so it never depends combinationally on cmd_valid
      r_cmd_ready <= (w_next_state == ST_IDLE);

      if (w_accept) begin
        r_wb_adr   <= cmd_adr;
        r_wb_dat_w <= cmd_dat;
        r_wb_sel   <= cmd_sel;
        r_wb_we    <= cmd_we;
        r_wb_cyc   <= 1'b1;
        r_tmo      <= 16'd0;
      end

      if (r_state == ST_BUS) begin
        if (w_done) begin
          r_wb_cyc     <= 1'b0;
          r_wb_we      <= 1'b0;
          r_rsp_valid  <= 1'b1;
          r_rsp_dat    <= w_rsp_dat;
          r_rsp_status <= w_status;
          r_txn_count  <= r_txn_count + CNT_W'(1);
          if (w_status != c_st_ack) begin
            r_err_count <= r_err_count + CNT_W'(1);
          end
        end else begin
          r_tmo <= r_tmo + 16'd1;
        end
      end

      if (w_rsp_take) begin
        r_rsp_valid <= 1'b0;
      end

      // a slave answering while no cycle is open is latched until reset
      if ((wb_ack || wb_err) && !r_wb_cyc) begin
        r_spurious <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_wb_cmd_master
// Brief    : Directed self-checking bench for wb_cmd_master (TIMEOUT = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [29:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_ack;
  logic        wb_err;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [15:0] txn_count;
  logic [15:0] err_count;
  logic        spurious;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc_cnt;

  wb_cmd_master #(
    .ADR_W  (30),
    .DAT_W  (32),
    .SEL_W  (4),
    .TIMEOUT(16),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_status(rsp_status),
    .wb_adr    (wb_adr),
    .wb_dat_w  (wb_dat_w),
    .wb_dat_r  (wb_dat_r),
    .wb_sel    (wb_sel),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .wb_cti    (wb_cti),
    .wb_bte    (wb_bte),
    .txn_count (txn_count),
    .err_count (err_count),
    .spurious  (spurious)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [29:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b1;
    wb_dat_r  = '0;
    wb_ack    = 1'b0;
    wb_err    = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_cyc",       32'(wb_cyc),     32'd0);
    chk("rst_stb",       32'(wb_stb),     32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready),  32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
    chk("rst_txn",       32'(txn_count),  32'd0);
    chk("rst_err",       32'(err_count),  32'd0);
    chk("rst_spurious",  32'(spurious),   32'd0);
    chk("rst_cti_bte",   32'({wb_cti, wb_bte}), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- read, ack on third BUS edge ----------------
    send_cmd(1'b0, 30'h10, 32'h0, 4'hF);
    tick();                                    // accepted
    cmd_valid = 1'b0;
    chk("rd_cyc0",       32'(wb_cyc),    32'd1);
    chk("rd_stb0",       32'(wb_stb),    32'd1);
    chk("rd_we",         32'(wb_we),     32'd0);
    chk("rd_adr",        32'(wb_adr),    32'h10);
    chk("rd_cmd_ready",  32'(cmd_ready), 32'd0);
    tick();
    chk("rd_cyc1",       32'(wb_cyc),    32'd1);
    tick();
    chk("rd_cyc2",       32'(wb_cyc),    32'd1);
    wb_ack   = 1'b1;
    wb_dat_r = 32'hDEADBEEF;
    tick();                                    // terminates with ack
    wb_ack   = 1'b0;
    chk("rd_cyc_end",    32'(wb_cyc),     32'd0);
    chk("rd_rsp_valid",  32'(rsp_valid),  32'd1);
    chk("rd_rsp_dat",    rsp_dat,         32'hDEADBEEF);
    chk("rd_rsp_status", 32'(rsp_status), 32'd0);
    chk("rd_txn",        32'(txn_count),  32'd1);
    chk("rd_err",        32'(err_count),  32'd0);
    tick();                                    // response handshake
    chk("rd_rsp_taken",  32'(rsp_valid),  32'd0);
    chk("rd_ready_back", 32'(cmd_ready),  32'd1);

    // ---------------- write, ack in first BUS cycle ----------------
    send_cmd(1'b1, 30'h4, 32'h12345678, 4'b0011);
    tick();                                    // accepted
    cmd_valid = 1'b0;
    chk("wr_we",         32'(wb_we),     32'd1);
    chk("wr_sel",        32'(wb_sel),    32'b0011);
    chk("wr_dat",        wb_dat_w,       32'h12345678);
    chk("wr_adr",        32'(wb_adr),    32'h4);
    chk("wr_rsp_early",  32'(rsp_valid), 32'd0);
    wb_ack   = 1'b1;
    wb_dat_r = 32'hFFFFFFFF;
    tick();                                    // second cycle: response up
    wb_ack   = 1'b0;
    chk("wr_rsp_valid",  32'(rsp_valid),  32'd1);
    chk("wr_rsp_dat",    rsp_dat,         32'd0);
    chk("wr_rsp_status", 32'(rsp_status), 32'd0);
    chk("wr_we_drop",    32'(wb_we),      32'd0);
    chk("wr_txn",        32'(txn_count),  32'd2);
    tick();
    chk("wr_ready_back", 32'(cmd_ready),  32'd1);
    chk("wr_spurious",   32'(spurious),   32'd0);

    // ---------------- read with ack and err together ----------------
    send_cmd(1'b0, 30'h8, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    wb_ack    = 1'b1;
    wb_err    = 1'b1;
    wb_dat_r  = 32'hAAAA5555;
    tick();
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
    chk("err_rsp_valid",  32'(rsp_valid),  32'd1);
    chk("err_rsp_status", 32'(rsp_status), 32'd1);
    chk("err_rsp_dat",    rsp_dat,         32'd0);
    chk("err_err_count",  32'(err_count),  32'd1);
    chk("err_txn",        32'(txn_count),  32'd3);
    tick();

    // ---------------- timeout (16 cycles), late ack ----------------
    rsp_ready = 1'b0;
    send_cmd(1'b0, 30'hC, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    cyc_cnt = 0;
    for (int i = 0; i < 40 && wb_cyc; i++) begin
      cyc_cnt++;
      tick();
    end
    chk("tmo_cyc_cycles",  32'(cyc_cnt),    32'd16);
    chk("tmo_rsp_valid",   32'(rsp_valid),  32'd1);
    chk("tmo_rsp_status",  32'(rsp_status), 32'd2);
    chk("tmo_rsp_dat",     rsp_dat,         32'd0);
    chk("tmo_err_count",   32'(err_count),  32'd2);
    chk("tmo_txn",         32'(txn_count),  32'd4);
    chk("tmo_no_spurious", 32'(spurious),   32'd0);
    wb_ack   = 1'b1;
    wb_dat_r = 32'h00001234;
    tick();                                    // late ack while in RSP
    wb_ack   = 1'b0;
    chk("late_spurious",   32'(spurious),   32'd1);
    chk("late_status",     32'(rsp_status), 32'd2);
    chk("late_dat",        rsp_dat,         32'd0);

    // ---------------- stalled response, pending second command ----------------
    send_cmd(1'b0, 30'h20, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_rsp_valid", 32'(rsp_valid),  32'd1);
      chk("stall_status",    32'(rsp_status), 32'd2);
      chk("stall_dat",       rsp_dat,         32'd0);
      chk("stall_cmd_ready", 32'(cmd_ready),  32'd0);
      chk("stall_cyc",       32'(wb_cyc),     32'd0);
    end
    rsp_ready = 1'b1;
    tick();                                    // response handshake
    chk("stall_taken",     32'(rsp_valid), 32'd0);
    chk("stall_ready",     32'(cmd_ready), 32'd1);
    chk("stall_not_yet",   32'(wb_cyc),    32'd0);
    tick();                                    // second command accepted
    cmd_valid = 1'b0;
    chk("second_cyc",      32'(wb_cyc),    32'd1);
    chk("second_adr",      32'(wb_adr),    32'h20);
    wb_ack   = 1'b1;
    wb_dat_r = 32'h0BADF00D;
    tick();
    wb_ack   = 1'b0;
    chk("second_rsp_dat",  rsp_dat,        32'h0BADF00D);
    chk("second_txn",      32'(txn_count), 32'd5);
    tick();

    // ---------------- asynchronous reset mid-BUS ----------------
    send_cmd(1'b0, 30'h30, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("arst_pre_cyc",    32'(wb_cyc),    32'd1);
    #1;
    reset = 1'b1;
    #1;                                        // well before the next edge
    chk("arst_cyc",        32'(wb_cyc),    32'd0);
    chk("arst_stb",        32'(wb_stb),    32'd0);
    chk("arst_txn",        32'(txn_count), 32'd0);
    chk("arst_err",        32'(err_count), 32'd0);
    chk("arst_spurious",   32'(spurious),  32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("arst_ready",      32'(cmd_ready), 32'd1);
    chk("arst_no_rsp",     32'(rsp_valid), 32'd0);
    send_cmd(1'b0, 30'h7, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    wb_ack   = 1'b1;
    wb_dat_r = 32'h55AA55AA;
    tick();
    wb_ack   = 1'b0;
    chk("post_rsp_valid",  32'(rsp_valid),  32'd1);
    chk("post_rsp_dat",    rsp_dat,         32'h55AA55AA);
    chk("post_status",     32'(rsp_status), 32'd0);
    chk("post_txn",        32'(txn_count),  32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
